// File: rtl/ov_7670_capture.sv
// Purpose : capture OV7670 VSYNC/HREF/D byte stream, pack byte pairs into RGB565 pixels with X/Y and frame markers.
// Latency : second byte of a pair sampled at PCLK edge N -> pixel_valid high after edge N+1, for one cycle.
// Backpress: none; the camera cannot be stalled, so the frame-buffer writer must take every pixel_valid strobe.
//
// Ports:
//   clk          camera pixel clock (PCLK); every flop uses the rising edge
//   reset        asynchronous, active-low
//   enable       capture permitted (init done), level-sensitive
//   vsync/href/d camera video bus
//   pixel        {first byte, second byte}, qualified by pixel_valid
//   x / y        column / row of the emitted pixel
//   frame_start  with the pixel at x=0,y=0 of a frame
//   frame_done   one-cycle pulse when a captured frame closes
//   err          sticky: odd byte count on a line, H or V overrun
module ov_7670_capture #(
   parameter int H_PIXELS = 640,
   parameter int V_LINES  = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        vsync,
   input  logic        href,
   input  logic [7:0]  d,
   output logic [15:0] pixel,
   output logic        pixel_valid,
   output logic [9:0]  x,
   output logic [8:0]  y,
   output logic        frame_start,
   output logic        frame_done,
   output logic        err
);

   localparam logic [9:0] X_MAX = 10'(H_PIXELS);
   localparam logic [8:0] Y_MAX = 9'(V_LINES);

   typedef enum logic [1:0] {S_IDLE, S_SYNC, S_VBLANK, S_ACTIVE} state_t;

   state_t      state_q;
   logic        vsync_q, vsync_qq, href_q, href_qq;
   logic [7:0]  d_q, hi_q;
   logic        phase_q, first_q, line_pix_q;
   logic [9:0]  x_cnt_q;
   logic [8:0]  y_cnt_q;
   logic [15:0] pixel_q;
   logic        pixel_valid_q, frame_start_q, frame_done_q, err_q;
   logic [9:0]  x_q;
   logic [8:0]  y_q;

   logic vs_rise, vs_fall, href_fall;

   // Edges are taken between the registered bus and a one-cycle-older copy.
   assign vs_rise   =  vsync_q & ~vsync_qq;
   assign vs_fall   = ~vsync_q &  vsync_qq;
   assign href_fall = ~href_q  &  href_qq;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q  <= 1'b0;
         vsync_qq <= 1'b0;
         href_q   <= 1'b0;
         href_qq  <= 1'b0;
         d_q      <= 8'h00;
      end else begin
         vsync_q  <= vsync;
         vsync_qq <= vsync_q;
         href_q   <= href;
         href_qq  <= href_q;
         d_q      <= d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         hi_q          <= 8'h00;
         phase_q       <= 1'b0;
         first_q       <= 1'b0;
         line_pix_q    <= 1'b0;
         x_cnt_q       <= 10'd0;
         y_cnt_q       <= 9'd0;
         pixel_q       <= 16'h0000;
         pixel_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         err_q         <= 1'b0;
         x_q           <= 10'd0;
         y_q           <= 9'd0;
      end else begin
         pixel_valid_q <= 1'b0;
         frame_start_q <= 1'b0;
         frame_done_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (enable) state_q <= S_SYNC;
            end
            // Any frame already in flight is skipped; capture begins on a boundary.
            S_SYNC: begin
               if (!enable)      state_q <= S_IDLE;
               else if (vs_rise) state_q <= S_VBLANK;
            end
            S_VBLANK: begin
               x_cnt_q    <= 10'd0;
               y_cnt_q    <= 9'd0;
               phase_q    <= 1'b0;
               first_q    <= 1'b1;
               line_pix_q <= 1'b0;
               if (!enable)      state_q <= S_IDLE;
               else if (vs_fall) state_q <= S_ACTIVE;
            end
            S_ACTIVE: begin
               // Frame close outranks any line byte arriving in the same cycle.
               if (vs_rise) begin
                  frame_done_q <= 1'b1;
                  if (phase_q) err_q <= 1'b1;
                  phase_q <= 1'b0;
                  state_q <= enable ? S_VBLANK : S_IDLE;
               end else if (href_q) begin
                  if (!phase_q) begin
                     hi_q    <= d_q;
                     phase_q <= 1'b1;
                  end else begin
                     phase_q <= 1'b0;
                     // Overrun pixels are dropped; counters hold at the limit.
                     if (y_cnt_q == Y_MAX || x_cnt_q == X_MAX) begin
                        err_q <= 1'b1;
                     end else begin
                        pixel_q       <= {hi_q, d_q};
                        pixel_valid_q <= 1'b1;
                        frame_start_q <= first_q;
                        x_q           <= x_cnt_q;
                        y_q           <= y_cnt_q;
                        first_q       <= 1'b0;
                        line_pix_q    <= 1'b1;
                        x_cnt_q       <= x_cnt_q + 10'd1;
                     end
                  end
               end else if (href_fall) begin
                  x_cnt_q    <= 10'd0;
                  line_pix_q <= 1'b0;
                  // Blank lines (no pixel emitted) do not advance the row.
                  if (line_pix_q) y_cnt_q <= y_cnt_q + 9'd1;
                  if (phase_q) err_q <= 1'b1;
                  phase_q <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign pixel       = pixel_q;
   assign pixel_valid = pixel_valid_q;
   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign frame_done  = frame_done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_ov_7670_capture.sv
module tb_ov_7670_capture;

   typedef struct packed {
      logic [15:0] pix;
      logic [9:0]  x;
      logic [8:0]  y;
      logic        fs;
   } px_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic        vsync;
   logic        href;
   logic [7:0]  d;
   logic [15:0] pixel;
   logic        pixel_valid;
   logic [9:0]  x;
   logic [8:0]  y;
   logic        frame_start;
   logic        frame_done;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;
   int fd_cnt = 0;
   int exp_fd = 0;

   px_t exp_q[$];
   px_t obs_q[$];

   ov_7670_capture #(.H_PIXELS(4), .V_LINES(3)) dut (
      .clk(clk), .reset(reset), .enable(enable), .vsync(vsync), .href(href), .d(d),
      .pixel(pixel), .pixel_valid(pixel_valid), .x(x), .y(y),
      .frame_start(frame_start), .frame_done(frame_done), .err(err)
   );

   always #5 clk = ~clk;

   // Outputs are collected on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (pixel_valid) obs_q.push_back({pixel, x, y, frame_start});
      if (frame_done) fd_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Queue expected pixels, then drive the line; optional first-pixel latency probe.
   task automatic send_line(input int nbytes, input logic [7:0] base, input int npix,
                            input int yv, input bit fs, input bit lat);
      logic [7:0] b0, b1;
      for (int i = 0; i < npix; i++) begin
         b0 = base + 8'(2 * i);
         b1 = base + 8'(2 * i + 1);
         exp_q.push_back({b0, b1, 10'(i), 9'(yv), fs && (i == 0)});
      end
      for (int i = 0; i < nbytes; i++) begin
         href = 1'b1;
         d    = base + 8'(i);
         tick(1);
         if (lat && i == 1) check("lat_before", 64'(pixel_valid), 64'd0);
         if (lat && i == 2) check("lat_strobe", 64'(pixel_valid), 64'd1);
      end
      href = 1'b0;
      d    = 8'h00;
      tick(3);
   endtask

   task automatic drain(input string tag);
      px_t e, o;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, "_present"}, 64'(obs_q.size() > 0), 64'd1);
         if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check({tag, "_pixel"}, 64'(o), 64'(e));
         end
      end
      check({tag, "_extra"}, 64'(obs_q.size()), 64'd0);
      obs_q.delete();
   endtask

   task automatic vs_pulse();
      href  = 1'b0;
      vsync = 1'b1;
      tick(3);
      vsync = 1'b0;
      tick(4);
   endtask

   // Close an active frame and check the frame_done pulse position and width.
   task automatic close_frame(input string tag);
      href  = 1'b0;
      vsync = 1'b1;
      tick(1);
      check({tag, "_fd_early"}, 64'(frame_done), 64'd0);
      tick(1);
      check({tag, "_fd_pulse"}, 64'(frame_done), 64'd1);
      tick(1);
      check({tag, "_fd_width"}, 64'(frame_done), 64'd0);
      vsync = 1'b0;
      tick(4);
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      vsync  = 1'b0;
      href   = 1'b0;
      d      = 8'h00;
      tick(3);
      check("rst_pixel", 64'(pixel), 64'd0);
      check("rst_valid", 64'(pixel_valid), 64'd0);
      check("rst_x", 64'(x), 64'd0);
      check("rst_y", 64'(y), 64'd0);
      check("rst_fs", 64'(frame_start), 64'd0);
      check("rst_fd", 64'(frame_done), 64'd0);
      check("rst_err", 64'(err), 64'd0);

      // Enable mid-frame: no capture until a full vsync pulse.
      reset  = 1'b1;
      enable = 1'b1;
      tick(2);
      send_line(8, 8'hC0, 0, 0, 0, 0);
      send_line(8, 8'hC8, 0, 0, 0, 0);
      drain("midframe");

      // Two clean lines of four pixels.
      vs_pulse();
      send_line(8, 8'h12, 4, 0, 1, 1);
      send_line(8, 8'h80, 4, 1, 0, 0);
      drain("frame2x4");
      check("frame2x4_err", 64'(err), 64'd0);
      close_frame("frame2x4");
      exp_fd++;
      check("frame2x4_fdcnt", 64'(fd_cnt), 64'(exp_fd));

      // H overrun (12 bytes on a 4-pixel line), then V overrun on the 4th line.
      send_line(12, 8'h20, 4, 0, 1, 0);
      check("hover_err", 64'(err), 64'd1);
      send_line(8, 8'h30, 4, 1, 0, 0);
      send_line(8, 8'h38, 4, 2, 0, 0);
      send_line(8, 8'h90, 0, 3, 0, 0);
      drain("overrun");
      close_frame("overrun");
      exp_fd++;

      // Reset in the middle of an active line.
      exp_q.push_back({8'hA0, 8'hA1, 10'd0, 9'd0, 1'b1});
      for (int i = 0; i < 4; i++) begin
         href = 1'b1;
         d    = 8'hA0 + 8'(i);
         tick(1);
      end
      check("prerst_err", 64'(err), 64'd1);
      check("prerst_pixel", 64'(pixel), 64'hA0A1);
      reset = 1'b0;
      href  = 1'b0;
      #1;
      check("midrst_pixel", 64'(pixel), 64'd0);
      check("midrst_valid", 64'(pixel_valid), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      check("midrst_fs", 64'(frame_start), 64'd0);
      tick(2);
      drain("midrst");
      reset = 1'b1;
      tick(2);
      send_line(8, 8'hD0, 0, 0, 0, 0);
      drain("post_rst_wait");
      check("post_rst_fdcnt", 64'(fd_cnt), 64'(exp_fd));

      // Odd-length line, then a normal line that must restart at x=0, phase 0.
      vs_pulse();
      send_line(7, 8'h40, 3, 0, 1, 0);
      check("odd_err", 64'(err), 64'd1);
      send_line(8, 8'h50, 4, 1, 0, 0);
      drain("odd");
      close_frame("odd");
      exp_fd++;

      // Enable dropped mid-frame: frame completes, then nothing more.
      send_line(8, 8'h60, 4, 0, 1, 0);
      enable = 1'b0;
      send_line(8, 8'h70, 4, 1, 0, 0);
      drain("endrop");
      close_frame("endrop");
      exp_fd++;
      vs_pulse();
      send_line(8, 8'hE0, 0, 0, 0, 0);
      vs_pulse();
      drain("disabled");
      check("final_fdcnt", 64'(fd_cnt), 64'(exp_fd));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
